// File: rtl/imm_extend_unit.sv
`default_nettype none
// imm_extend_unit: extends IN_W-bit immediates to OUT_W bits (sign/zero/shifted/upper)
// and buffers the results in a DEPTH-entry FIFO behind a valid/ready handshake. Rev 1.0
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [1:0]                 out_mode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] zext_w;
  logic [OUT_W-1:0] shift_w;
  logic [OUT_W-1:0] upper_w;
  logic [OUT_W-1:0] ext_w;

  logic [OUT_W-1:0] data_mem_q [DEPTH];
  logic [1:0]       mode_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push_w;
  logic pop_w;

  assign sext_w  = OUT_W'($signed(in_data));
  assign zext_w  = OUT_W'(in_data);
  assign shift_w = sext_w << SHIFT;
  assign upper_w = zext_w << (OUT_W - IN_W);

  always_comb begin
    ext_w = sext_w;
    case (in_mode)
      2'd0:    ext_w = sext_w;
      2'd1:    ext_w = zext_w;
      2'd2:    ext_w = shift_w;
      default: ext_w = upper_w;
    endcase
  end

  // Status flags come only from registered occupancy, so no in->out combinational path.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push_w    = in_valid & in_ready & ~flush;
  assign pop_w     = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push_w) begin
      data_mem_q[wr_ptr_q] <= ext_w;
      mode_mem_q[wr_ptr_q] <= in_mode;
    end
  end

  assign out_data = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_mode = out_valid ? mode_mem_q[rd_ptr_q] : 2'd0;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, buffered immediate-extension unit: accepts IN_W-bit immediates with a per-item mode (sign-extend, zero-extend, sign-extend-and-shift, upper-load), produces OUT_W-bit results, and queues them in a DEPTH-entry FIFO behind a valid/ready handshake. It sits between instruction decode and the ALU/branch operand path. It generalises the plain 16→32 sign extender with width parameters, extension modes, back-pressure and flush.

## Interface
- IN_W, 16, immediate input width (≥1)
- OUT_W, 32, result width (≥ IN_W + SHIFT)
- SHIFT, 2, left-shift amount for mode 2 (branch word offset)
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous; empties the FIFO at the next edge
- in_valid  input  1  input item present
- in_ready  output  1  unit can accept (= not full)
- in_data  input  IN_W  immediate
- in_mode  input  2  0 sign-ext, 1 zero-ext, 2 sign-ext then << SHIFT, 3 upper-load
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head
- out_data  output  OUT_W  extended result at FIFO head; 0 when empty
- out_mode  output  2  mode tag of head entry; 0 when empty
- count  output  clog2(DEPTH+1)  current occupancy

## Operation
- Extension is combinational on in_data/in_mode; the result is written into the FIFO on push.
  - Mode 0: upper OUT_W−IN_W bits = in_data[IN_W−1], lower = in_data.
  - Mode 1: upper bits 0, lower = in_data.
  - Mode 2: mode-0 value shifted left by SHIFT, SHIFT LSBs = 0, truncated to OUT_W.
  - Mode 3: in_data placed in bits [OUT_W−1 : OUT_W−IN_W], all lower bits 0.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- FIFO: write pointer, read pointer, count; pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). No push when full, even if pop in same cycle.
- push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- flush: pointers and count cleared to 0 at the edge; any concurrent push or pop is discarded.
- in_data/in_mode are ignored when in_valid = 0 and when in_ready = 0.
- Entries are delivered strictly in acceptance order; each entry is delivered exactly once.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_mode = 0, count = 0; pointers 0.
- Reset asserted mid-operation: all queued entries are lost immediately, outputs go to their reset values without waiting for a clock edge.
- Latency: item accepted at edge k into an empty FIFO → out_valid = 1 with its out_data after edge k (visible in cycle k+1).
- Throughput: one item per cycle in and out when neither side stalls.
- out_valid, out_data, out_mode, count and in_ready are all derived from registered state only; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Full → drain: a pop at edge k raises in_ready in cycle k+1.
- out_data/out_mode hold stable while out_valid = 1 and out_ready = 0.

## Test plan
- Defaults. Modes 0/1/2/3 with in_data = 16'hF000 / 16'h8310 / 16'h9999 / 16'h0011, out_ready = 1 → out_data = 32'hFFFFF000 / 32'h00008310 / 32'hFFFE6664 / 32'h00110000, each one cycle after acceptance, with out_mode matching.
- Full: out_ready = 0, push 16'h0001..16'h0004 in mode 0 → count = 4, in_ready = 0; a 5th push of 16'h0005 is ignored. Then out_ready = 1 → 32'h1, 32'h2, 32'h3, 32'h4 in order, count returns to 0, no 32'h5.
- Wrap plus simultaneous push/pop: stream 10 items at in_valid = out_ready = 1 → count stays 1 and the order is preserved across pointer wrap. With count = 4, push + pop in the same cycle → pop only, count = 3.
- Flush: 3 entries queued, flush = 1 with in_valid = 1 → count = 0, out_valid = 0 next cycle, and the flushed-cycle input is not stored.
- Reset mid-stream: 2 entries queued, reset pulse between clock edges → out_valid = 0, count = 0, in_ready = 1 immediately. After release, a mode-0 push of 16'h8000 → 32'hFFFF8000.
